// File: rtl/alu_div_unit_if.sv
// Start/busy/done request channel between pipeline control and the iterative divider.
interface alu_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (output start, op, a, b, input busy, done, result);
    modport slave  (input start, op, a, b, output busy, done, result);
endinterface

// File: rtl/alu_div_unit.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and finish on the next edge.
module alu_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    alu_div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t             state;
    logic               op_rem;
    logic               quo_sign;
    logic               rem_sign;
    logic               special;
    logic [WIDTH-1:0]   special_val;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [CNT_W-1:0]   cnt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;

    logic               is_signed;
    logic               b_zero;
    logic               ovf;
    logic [WIDTH:0]     rem_sh;
    logic               trial_ge;
    logic [WIDTH-1:0]   trial;

    function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v, input logic en);
        abs_val = (en && v < 0) ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    function automatic logic [WIDTH-1:0] sign_fix(input logic [WIDTH-1:0] v, input logic neg);
        sign_fix = neg ? (~v + WIDTH'(1)) : v;
    endfunction

    always_comb begin
        is_signed = ~bus.op[0];
        b_zero    = (bus.b == '0);
        ovf       = is_signed && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);
        // Shifted remainder keeps the carried-out bit so large unsigned divisors compare correctly
        rem_sh    = {rem, quo[WIDTH-1]};
        trial_ge  = (rem_sh >= {1'b0, divisor});
        trial     = rem_sh[WIDTH-1:0] - divisor;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            op_rem      <= 1'b0;
            quo_sign    <= 1'b0;
            rem_sign    <= 1'b0;
            special     <= 1'b0;
            special_val <= '0;
            divisor     <= '0;
            rem         <= '0;
            quo         <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        op_rem   <= bus.op[1];
                        quo_sign <= is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        rem_sign <= is_signed & bus.a[WIDTH-1];
                        quo      <= abs_val(bus.a, is_signed);
                        divisor  <= abs_val(bus.b, is_signed);
                        rem      <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        special  <= b_zero | ovf;
                        if (b_zero)
                            special_val <= bus.op[1] ? bus.a : '1;
                        else
                            special_val <= bus.op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
                        state    <= (b_zero || ovf) ? FIN : CALC;
                    end
                end
                CALC: begin
                    rem <= trial_ge ? trial : rem_sh[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], trial_ge};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH-1))
                        state <= FIN;
                end
                FIN: begin
                    if (special)
                        result <= special_val;
                    else if (op_rem)
                        result <= sign_fix(rem, rem_sign);
                    else
                        result <= sign_fix(quo, quo_sign);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result;
endmodule

// File: tb/tb_alu_div_unit.sv
// Directed bench for alu_div_unit: latency, signed/unsigned results, fast paths, handshake and abort.
module tb_alu_div_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    alu_div_unit_if #(.WIDTH(32)) bus ();

    alu_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one op and wait for done; cycles counts samples from the start edge to done.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int cycles, output int busy_cycles);
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        tick();
        bus.start = 1'b0;
        bus.a = 32'hDEAD_BEEF;
        bus.b = 32'h0000_0001;
        cycles = 1;
        busy_cycles = 0;
        while (bus.done !== 1'b1 && cycles < 100) begin
            if (bus.busy === 1'b1) busy_cycles++;
            tick();
            cycles++;
        end
        res = bus.result;
    endtask

    task automatic check_op(input string name, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_res, input int exp_cycles);
        logic [31:0] res;
        int cyc;
        int bcyc;
        run_op(op, a, b, res, cyc, bcyc);
        checks++;
        if (res !== exp_res) begin
            errors++;
            $display("FAIL %s result: got %h expected %h", name, res, exp_res);
        end
        checks++;
        if (cyc !== exp_cycles) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, cyc, exp_cycles);
        end
        checks++;
        if (bcyc !== exp_cycles - 1) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, bcyc, exp_cycles - 1);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_width: got %b expected 0", name, bus.done);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++;
        if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", bus.result); end
    endtask

    task automatic test_arith();
        check_op("div_neg7_2",   2'd0, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 34);
        check_op("rem_neg7_2",   2'd2, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 34);
        check_op("remu_ffff_16", 2'd3, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 34);
        check_op("divu_ffff_16", 2'd1, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 34);
        check_op("divu_big_div", 2'd1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 34);
        check_op("remu_big_div", 2'd3, 32'hFFFF_FFFE, 32'h8000_0001, 32'h7FFF_FFFD, 34);
    endtask

    task automatic test_div_zero();
        check_op("div_by_zero",  2'd0, 32'h1234, 32'h0, 32'hFFFF_FFFF, 2);
        check_op("rem_by_zero",  2'd2, 32'h1234, 32'h0, 32'h0000_1234, 2);
        check_op("remu_by_zero", 2'd3, 32'h8000_0000, 32'h0, 32'h8000_0000, 2);
    endtask

    task automatic test_overflow();
        check_op("div_overflow", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        check_op("rem_overflow", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);
    endtask

    task automatic test_back_to_back();
        int cyc;
        int dones;
        bus.start = 1'b1; bus.op = 2'd1; bus.a = 32'd100; bus.b = 32'd7;
        tick();
        bus.start = 1'b0;
        cyc = 1;
        dones = 0;
        while (cyc < 100 && bus.done !== 1'b1) begin
            if (cyc == 5) begin
                bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'd5; bus.b = 32'd1;
            end else if (cyc == 6) begin
                bus.start = 1'b0;
            end else if (cyc == 8) begin
                bus.start = 1'b1; bus.op = 2'd3; bus.a = 32'd100; bus.b = 32'd7;
            end
            tick();
            cyc++;
        end
        checks++;
        if (cyc !== 34) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 34", cyc); end
        checks++;
        if (bus.result !== 32'd14) begin errors++; $display("FAIL b2b_divu_result: got %0d expected 14", bus.result); end
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: got done=%b busy=%b expected done=0 busy=1", bus.done, bus.busy);
        end
        cyc = 1;
        while (cyc < 100 && bus.done !== 1'b1) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc !== 34) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 34", cyc); end
        checks++;
        if (bus.result !== 32'd2) begin errors++; $display("FAIL b2b_remu_result: got %0d expected 2", bus.result); end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL b2b_extra_done: got %0d expected 0", dones); end
    endtask

    task automatic test_reset_abort();
        int dones;
        int busys;
        bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'd1000; bus.b = 32'd3;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", bus.done); end
        checks++;
        if (bus.result !== 32'h0) begin errors++; $display("FAIL abort_result: got %h expected 0", bus.result); end
        tick();
        rst_n = 1'b1;
        dones = 0;
        busys = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done === 1'b1) dones++;
            if (bus.busy === 1'b1) busys++;
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", dones); end
        checks++;
        if (busys !== 0) begin errors++; $display("FAIL abort_no_busy: got %0d expected 0", busys); end
        check_op("div_after_abort", 2'd0, 32'd1000, 32'd3, 32'd333, 34);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op = 2'd0;
        bus.a = '0;
        bus.b = '0;
        rst_n = 1'b0;
        repeat (2) tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_arith();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
